// File: rtl/fir_dir.sv
// rtl/fir_dir.sv - direct-form FIR filter with one time-multiplexed multiplier-accumulator
//
// Purpose:
//   Accepts one signed sample, then runs N = FIR_ORDER+1 MAC cycles over a
//   circular delay line and the coefficient ROM. It presents one output
//   sample and holds it until the sink takes it.
//   Build option FIRDIR_SAT_EN: saturate the shifted result to DOUT_WIDTH.
//   When it is undefined, the result wraps (low DOUT_WIDTH bits are kept).
//
// Ports:
//   clk       in   1           rising-edge clock
//   reset     in   1           synchronous active-high reset
//   asiValid  in   1           input sample valid
//   asiData   in   DIN_WIDTH   signed input sample
//   asiRdy    out  1           block can accept a sample (IDLE only)
//   asoValid  out  1           output sample valid
//   asoData   out  DOUT_WIDTH  signed output sample, held between outputs
//   asoRdy    in   1           sink accepts output
//
// Coefficients:
//   In the vendor flow, the ROM is initialised from COEF_INIT_FILE through the
//   ram_init_file attribute. COEF_VALUES carries the same contents for
//   simulation and for flows that have no MIF support. h[k] sits at bits
//   [k*COEF_WIDTH +: COEF_WIDTH].
`timescale 1ns/1ps

module fir_dir #(
  parameter string COEF_INIT_FILE = "romcoef.mif",
  parameter int    FIR_ORDER      = 32,
  parameter int    COEF_WIDTH     = 16,
  parameter int    DIN_WIDTH      = 16,
  parameter int    ACC_WIDTH      = 40,
  parameter int    DOUT_WIDTH     = 16,
  parameter int    DOUT_SHIFT     = 15,
  parameter logic [(FIR_ORDER+1)*COEF_WIDTH-1:0] COEF_VALUES = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         asiValid,
  input  logic signed [DIN_WIDTH-1:0]  asiData,
  output logic                         asiRdy,
  output logic                         asoValid,
  output logic signed [DOUT_WIDTH-1:0] asoData,
  input  logic                         asoRdy
);

  localparam int N    = FIR_ORDER + 1;
  localparam int PW   = DIN_WIDTH + COEF_WIDTH;
  localparam int AW   = (N > 1) ? $clog2(N) : 1;
  localparam int CNTW = $clog2(N + 3);

  localparam logic [AW-1:0]   PTR_LAST   = AW'(N - 1);
  localparam logic [CNTW-1:0] CLEAR_LAST = CNTW'(N - 1);
  localparam logic [CNTW-1:0] FETCH_END  = CNTW'(N);
  // N fetch cycles plus three pipeline stages (fetch, multiply, accumulate).
  // The accumulator is final when cnt reaches N+2.
  localparam logic [CNTW-1:0] CALC_LAST  = CNTW'(N + 2);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_CALC, S_OUT} state_t;

  state_t                         state, state_nxt;
  logic [CNTW-1:0]                cnt;
  logic [AW-1:0]                  wptr, rptr;
  logic signed [DIN_WIDTH-1:0]    dline [N];
  (* ram_init_file = COEF_INIT_FILE *)
  logic signed [COEF_WIDTH-1:0]   coef_rom [N];
  logic signed [DIN_WIDTH-1:0]    x_q;
  logic signed [COEF_WIDTH-1:0]   h_q;
  logic signed [PW-1:0]           prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext, acc;
  logic signed [DOUT_WIDTH-1:0]   result;
  logic                           fetch, fetch_v, fetch_first, prod_v, prod_first;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      coef_rom[i] = COEF_VALUES[i*COEF_WIDTH +: COEF_WIDTH];
    end
  end

  always_comb begin
    state_nxt = state;
    asiRdy    = 1'b0;
    case (state)
      S_CLEAR: if (cnt == CLEAR_LAST) state_nxt = S_IDLE;
      S_IDLE: begin
        asiRdy = 1'b1;
        if (asiValid) state_nxt = S_CALC;
      end
      S_CALC:  if (cnt == CALC_LAST) state_nxt = S_OUT;
      S_OUT:   if (asoRdy) state_nxt = S_IDLE;
      default: state_nxt = S_CLEAR;
    endcase
  end

  assign fetch    = (state == S_CALC) && (cnt < FETCH_END);
  // A signed size cast sign-extends the product into the accumulator width.
  assign prod_ext = ACC_WIDTH'(prod);

`ifdef FIRDIR_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};
  logic signed [ACC_WIDTH-1:0] shifted;

  always_comb begin
    shifted = acc >>> DOUT_SHIFT;
    if (shifted > SAT_MAX)      result = SAT_MAX[DOUT_WIDTH-1:0];
    else if (shifted < SAT_MIN) result = SAT_MIN[DOUT_WIDTH-1:0];
    else                        result = shifted[DOUT_WIDTH-1:0];
  end
`else
  always_comb begin
    result = DOUT_WIDTH'(acc >>> DOUT_SHIFT);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_CLEAR;
      cnt         <= '0;
      wptr        <= '0;
      rptr        <= '0;
      acc         <= '0;
      fetch_v     <= 1'b0;
      fetch_first <= 1'b0;
      prod_v      <= 1'b0;
      prod_first  <= 1'b0;
      asoValid    <= 1'b0;
      asoData     <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)                    cnt <= '0;
      else if (state == S_CLEAR || state == S_CALC) cnt <= cnt + 1'b1;

      // In CLEAR, wptr sweeps every slot once and wraps back to 0.
      if (state == S_CLEAR || (state == S_IDLE && asiValid)) begin
        wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
      end
      if (state == S_IDLE && asiValid) begin
        rptr <= wptr;
      end else if (fetch) begin
        rptr <= (rptr == '0) ? PTR_LAST : rptr - 1'b1;
      end

      fetch_v     <= fetch;
      fetch_first <= fetch && (cnt == '0);
      prod_v      <= fetch_v;
      prod_first  <= fetch_first;
      if (prod_v) acc <= prod_first ? prod_ext : acc + prod_ext;

      if (state == S_CALC && state_nxt == S_OUT) begin
        asoValid <= 1'b1;
        asoData  <= result;
      end else if (state == S_OUT && asoRdy) begin
        asoValid <= 1'b0;
      end
    end
  end

  // Datapath storage without reset. The CLEAR state zeroes the delay line.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR)                 dline[wptr] <= '0;
    else if (state == S_IDLE && asiValid) dline[wptr] <= asiData;
    if (fetch) begin
      x_q <= dline[rptr];
      h_q <= coef_rom[cnt[AW-1:0]];
    end
    prod <= x_q * h_q;
  end

endmodule

// File: tb/tb_fir_dir.sv
// tb/tb_fir_dir.sv - scoreboard testbench for fir_dir
`timescale 1ns/1ps

module tb_fir_dir;

  localparam int N   = 33;
  localparam int LAT = N + 3;

  function automatic logic signed [15:0] coef_of(input int k);
    int v;
    if (k == 0 || k == 5) return 16'h8000;
    if (k == 1) return 16'h7FFF;
    v = (k * 12345 + 678) % 65536;
    return v[15:0];
  endfunction

  function automatic logic [N*16-1:0] mk_coefs();
    logic [N*16-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k*16 +: 16] = coef_of(k);
    return r;
  endfunction

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               asiValid = 1'b0;
  logic signed [15:0] asiData = '0;
  logic               asiRdy;
  logic               asoValid;
  logic signed [15:0] asoData;
  logic               asoRdy = 1'b1;

  always #5 clk = ~clk;

  fir_dir #(
    .COEF_INIT_FILE (""),
    .COEF_VALUES    (mk_coefs())
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .asiValid (asiValid),
    .asiData  (asiData),
    .asiRdy   (asiRdy),
    .asoValid (asoValid),
    .asoData  (asoData),
    .asoRdy   (asoRdy)
  );

  int                 checks = 0;
  int                 failures = 0;
  longint             cyc = 0;
  int                 rdy_mode = 0;
  logic signed [15:0] hist [N];
  logic signed [15:0] exp_q [$];
  longint             acc_q [$];
  logic               rst_q = 1'b1, prev_rst = 1'b1;
  logic               prev_valid = 1'b0, prev_rdy = 1'b0;
  logic signed [15:0] prev_data = '0;

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic signed [15:0] model_y();
    logic signed [63:0] s;
    logic signed [39:0] a;
    logic signed [39:0] sh;
    s = 0;
    for (int k = 0; k < N; k++) s += longint'(coef_of(k)) * longint'(hist[k]);
    a  = s[39:0];
    sh = a >>> 15;
`ifdef FIRDIR_SAT_EN
    if (sh > 32767)  return 16'h7FFF;
    if (sh < -32768) return 16'h8000;
`endif
    return sh[15:0];
  endfunction

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  initial forever begin
    @(posedge clk);
    #2;
    asoRdy = (rdy_mode == 0) ? 1'b1 : ((cyc / 12) % 2 == 0);
  end

  always @(negedge clk) begin
    if (!rst_q && !prev_rst) begin
      if (prev_valid && !prev_rdy) chk("hold_valid", asoValid, 1);
      if (prev_valid && prev_rdy)  chk("gap_after_output", asoValid, 0);
      if (!(asoValid && !prev_valid)) chk("data_hold", asoData, prev_data);
      if (asoValid && !prev_valid) begin
        chk("pending_on_rise", acc_q.size() > 0, 1);
        if (acc_q.size() > 0) chk("latency", cyc - acc_q[0], LAT);
      end
      if (asoValid && asoRdy) begin
        chk("output_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("dout", asoData, exp_q.pop_front());
          void'(acc_q.pop_front());
        end
      end
    end
    prev_rst   <= rst_q;
    prev_valid <= asoValid;
    prev_rdy   <= asoRdy;
    prev_data  <= asoData;
  end

  task automatic send(input logic signed [15:0] x);
    int n;
    n = 0;
    asiData  = x;
    asiValid = 1'b1;
    while (!asiRdy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("accept", asiRdy, 1);
    if (asiRdy) begin
      for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = x;
      exp_q.push_back(model_y());
      acc_q.push_back(cyc + 1);
    end
    @(negedge clk);
    asiValid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < N; k++) hist[k] = '0;
    exp_q.delete();
    acc_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < N; k++) hist[k] = '0;
    repeat (10) @(negedge clk);
    chk("reset_asiRdy", asiRdy, 0);
    chk("reset_asoValid", asoValid, 0);
    chk("reset_asoData", asoData, 0);
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("clear_asiRdy", asiRdy, 0);
      chk("clear_asoValid", asoValid, 0);
      chk("clear_asoData", asoData, 0);
      @(negedge clk);
    end
    chk("idle_asiRdy", asiRdy, 1);

    send(16'sd16384);
    repeat (40) send(16'sd0);
    drain();

    repeat (40) send(16'h8000);
    drain();

    rdy_mode = 1;
    for (int i = 0; i < 60; i++) begin
      logic [15:0] r;
      r = 16'($urandom_range(0, 65535));
      send(r);
    end
    drain();
    rdy_mode = 0;

    send(16'sd12345);
    repeat (10) @(negedge clk);
    do_reset(3);
    repeat (N + 2) @(negedge clk);
    send(16'sd16384);
    repeat (35) send(16'sd0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
